// File: rtl/cipher_pkg.sv
// Shared types and constants for the character-cipher feeder path.
package cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned CHAR_W = 8;
    localparam int unsigned KEY_W  = 3;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/char_fifo.sv
// Synchronous character FIFO; the head entry is visible combinationally on head_data.
module char_fifo
    import cipher_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  logic [CHAR_W-1:0]        push_data,
    input  logic                     pop,
    output logic [CHAR_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [CHAR_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // full/empty come from the pre-edge count, so a same-cycle pop never frees room for a push
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cipher_feeder.sv
// Buffers ASCII bytes and presents them to the EncDec cipher, one character per HOLD cycles.
module cipher_feeder
    import cipher_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned HOLD  = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   wr_en,
    input  logic [CHAR_W-1:0]      wr_data,
    output logic                   full,
    output logic                   overflow,
    input  logic [KEY_W-1:0]       key_in,
    input  logic                   mode_in,
    input  logic                   cfg_load,
    input  logic                   start,
    output logic                   busy,
    output logic [CHAR_W-1:0]      inp,
    output logic                   select,
    output logic [KEY_W-1:0]       key,
    output logic                   out_valid,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [KEY_W-1:0]  cfg_key_q, cfg_key_d;
    logic              cfg_mode_q, cfg_mode_d;
    logic [CHAR_W-1:0] inp_q, inp_d;
    logic              select_q, select_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic [CHAR_W-1:0] head_data;

    char_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .full      (full)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cfg_key_d  = cfg_key_q;
        cfg_mode_d = cfg_mode_q;
        inp_d      = inp_q;
        select_d   = select_q;
        key_d      = key_q;
        overflow_d = overflow_q | (wr_en & full);
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    cfg_key_d  = key_in;
                    cfg_mode_d = mode_in;
                end
                if (start && (count != '0)) begin
                    pop      = 1'b1;
                    inp_d    = head_data;
                    select_d = cfg_mode_q;
                    key_d    = cfg_key_q;
                    hold_d   = '0;
                    state_d  = ST_FEED;
                end
            end
            ST_FEED: begin
                if (hold_q == HOLD_LAST) begin
                    if (count != '0) begin
                        pop    = 1'b1;
                        inp_d  = head_data;
                        hold_d = '0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            cfg_key_q  <= '0;
            cfg_mode_q <= 1'b0;
            inp_q      <= '0;
            select_q   <= 1'b0;
            key_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cfg_key_q  <= cfg_key_d;
            cfg_mode_q <= cfg_mode_d;
            inp_q      <= inp_d;
            select_q   <= select_d;
            key_q      <= key_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_FEED);
    assign done      = (state_q == ST_DONE);
    assign inp       = inp_q;
    assign select    = select_q;
    assign key       = key_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cipher_feeder.sv
// Directed bench for cipher_feeder (DEPTH=16, HOLD=2) with hand-computed expectations.
module tb_cipher_feeder;

    logic       CLK;
    logic       RST;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       overflow;
    logic [2:0] key_in;
    logic       mode_in;
    logic       cfg_load;
    logic       start;
    logic       busy;
    logic [7:0] inp;
    logic       select;
    logic [2:0] key;
    logic       out_valid;
    logic       done;
    logic [4:0] count;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    cipher_feeder #(.DEPTH(16), .HOLD(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .overflow  (overflow),
        .key_in    (key_in),
        .mode_in   (mode_in),
        .cfg_load  (cfg_load),
        .start     (start),
        .busy      (busy),
        .inp       (inp),
        .select    (select),
        .key       (key),
        .out_valid (out_valid),
        .done      (done),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seq [4];

        RST = 1'b1; wr_en = 1'b0; wr_data = '0; key_in = '0; mode_in = 1'b0;
        cfg_load = 1'b0; start = 1'b0;
        #12;
        check("rst_inp",  32'(inp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt",  32'(count), 32'd0);
        check("rst_ovf",  32'(overflow), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_key",  32'(key), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        RST = 1'b0;
        tick();

        // single character, key=3 encrypt
        cfg_load = 1'b1; key_in = 3'd3; mode_in = 1'b0;
        tick();
        cfg_load = 1'b0;
        check("cfg_no_out", 32'(key), 32'd0);
        push(8'd65);
        check("t1_cnt", 32'(count), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_inp",   32'(inp), 32'd65);
            check("t1_sel",   32'(select), 32'd0);
            check("t1_key",   32'(key), 32'd3);
            check("t1_done0", 32'(done), 32'd0);
            tick();
        end
        check("t1_done",   32'(done), 32'd1);
        check("t1_valid0", 32'(out_valid), 32'd0);
        check("t1_busyd",  32'(busy), 32'd1);
        tick();
        check("t1_done_off", 32'(done), 32'd0);
        check("t1_idle",     32'(busy), 32'd0);
        check("t1_hold_inp", 32'(inp), 32'd65);

        // two characters, decrypt
        cfg_load = 1'b1; key_in = 3'd3; mode_in = 1'b1;
        tick();
        cfg_load = 1'b0;
        push(8'd65);
        push(8'd99);
        check("t2_cnt", 32'(count), 32'd2);
        exp_seq = '{8'd65, 8'd65, 8'd99, 8'd99};
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_inp",   32'(inp), 32'(exp_seq[i]));
            check("t2_sel",   32'(select), 32'd1);
            check("t2_done0", 32'(done), 32'd0);
            tick();
        end
        check("t2_done", 32'(done), 32'd1);
        tick();
        check("t2_done_off", 32'(done), 32'd0);
        check("t2_idle",     32'(busy), 32'd0);

        // overflow: 17 pushes into 16 entries
        for (int i = 0; i < 16; i++) push(8'(8'h41 + i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_cnt",  32'(count), 32'd16);
        check("t3_ovf0", 32'(overflow), 32'd0);
        push(8'h51);
        check("t3_cnt17", 32'(count), 32'd16);
        check("t3_ovf",   32'(overflow), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        check("t3_full_drop", 32'(full), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check("t3_inp_a", 32'(inp), 32'(8'h41 + i));
            tick();
            check("t3_inp_b", 32'(inp), 32'(8'h41 + i));
            check("t3_valid", 32'(out_valid), 32'd1);
            tick();
        end
        check("t3_done", 32'(done), 32'd1);
        tick();
        check("t3_idle",    32'(busy), 32'd0);
        check("t3_ovf_stk", 32'(overflow), 32'd1);

        // ignored controls
        start = 1'b1; tick(); start = 1'b0;
        check("t4_empty_start", 32'(busy), 32'd0);
        push(8'h61);
        push(8'h62);
        start = 1'b1; tick(); start = 1'b0;
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_inp0", 32'(inp), 32'h61);
        cfg_load = 1'b1; key_in = 3'd5; start = 1'b1;
        tick();
        cfg_load = 1'b0; start = 1'b0;
        check("t4_key_a", 32'(key), 32'd3);
        check("t4_inp1",  32'(inp), 32'h61);
        tick();
        check("t4_inp2",  32'(inp), 32'h62);
        check("t4_key_b", 32'(key), 32'd3);
        tick();
        check("t4_inp3", 32'(inp), 32'h62);
        tick();
        check("t4_done", 32'(done), 32'd1);
        tick();
        check("t4_idle", 32'(busy), 32'd0);
        tick();
        check("t4_no_restart", 32'(busy), 32'd0);

        // write landing during the first hold cycle joins the run
        push(8'd65);
        start = 1'b1; tick(); start = 1'b0;
        check("t5_inp0", 32'(inp), 32'd65);
        check("t5_key",  32'(key), 32'd3);
        wr_en = 1'b1; wr_data = 8'd66;
        tick();
        wr_en = 1'b0;
        check("t5_inp1", 32'(inp), 32'd65);
        check("t5_cnt",  32'(count), 32'd1);
        tick();
        check("t5_inp2",  32'(inp), 32'd66);
        check("t5_cnt0",  32'(count), 32'd0);
        check("t5_valid", 32'(out_valid), 32'd1);
        tick();
        check("t5_inp3",  32'(inp), 32'd66);
        check("t5_done0", 32'(done), 32'd0);
        tick();
        check("t5_done", 32'(done), 32'd1);
        tick();

        // asynchronous reset during the second character
        push(8'h31);
        push(8'h32);
        push(8'h33);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        tick();
        check("t6_inp_pre", 32'(inp), 32'h32);
        #2;
        RST = 1'b1;
        #1;
        check("t6_inp",   32'(inp), 32'd0);
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy",  32'(busy), 32'd0);
        check("t6_key",   32'(key), 32'd0);
        check("t6_sel",   32'(select), 32'd0);
        check("t6_cnt",   32'(count), 32'd0);
        check("t6_ovf",   32'(overflow), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_done", 32'(done), 32'd0);
            check("t6_idle",    32'(busy), 32'd0);
        end
        check("t6_cnt_after", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
